// File: rtl/subbytes_seq.sv
// Byte-serial AES SubBytes/InvSubBytes sequencer: streams the state through one shared,
// externally pipelined S-box and reassembles the substituted bytes into dout.
module subbytes_seq #(
    parameter int NBYTES = 16,
    parameter int SB_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dec,
    input  logic [8*NBYTES-1:0]   din,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   dout,
    output logic [7:0]            sb_in,
    output logic                  sb_dec,
    output logic                  sb_valid,
    input  logic [7:0]            sb_out
);

    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [8*NBYTES-1:0]   src_q, src_d;
    logic [8*NBYTES-1:0]   dout_q, dout_d;
    logic                  dec_q, dec_d;
    logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         cap_cnt_q, cap_cnt_d;
    logic                  cap_vld;

    // Issue side: one source byte per ISSUE cycle, outputs held at zero otherwise.
    always_comb begin
        sb_valid = (state_q == ISSUE);
        sb_dec   = sb_valid & dec_q;
        sb_in    = 8'h00;
        if (sb_valid) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (issue_cnt_q == CW'(b)) sb_in = src_q[8*b +: 8];
            end
        end
    end

    // Capture qualifier is the issue strobe delayed by the S-box latency; clearing it on
    // reset is what drops results still in flight from an aborted operation.
    generate
        if (SB_LAT == 0) begin : g_nolat
            assign cap_vld = sb_valid;
        end else begin : g_lat
            logic [SB_LAT-1:0] vld_dly_q, vld_dly_d;

            always_comb begin
                vld_dly_d    = vld_dly_q;
                vld_dly_d[0] = sb_valid;
                for (int k = 1; k < SB_LAT; k++) vld_dly_d[k] = vld_dly_q[k-1];
            end

            always_ff @(posedge clk) begin
                if (rst) vld_dly_q <= '0;
                else     vld_dly_q <= vld_dly_d;
            end

            assign cap_vld = vld_dly_q[SB_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dec_d       = dec_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        dout_d      = dout_q;

        if (cap_vld && (cap_cnt_q < CW'(NBYTES))) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (cap_cnt_q == CW'(b)) dout_d[8*b +: 8] = sb_out;
            end
            cap_cnt_d = cap_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ISSUE;
                    src_d       = din;
                    dec_d       = dec;
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + CW'(1);
                if (issue_cnt_q == CW'(NBYTES - 1)) state_d = (SB_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                // Leave exactly when the final byte is being captured.
                if (cap_vld && (cap_cnt_q == CW'(NBYTES - 1))) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dec_q       <= 1'b0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            dout_q      <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        src_q <= src_d;
    end

    assign busy = (state_q == ISSUE) || (state_q == DRAIN);
    assign done = (state_q == DONE);
    assign dout = dout_q;

endmodule

// File: doc/subbytes_seq.md
SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 Parameter NBYTES, default 16, is the number of state bytes processed per operation (legal 1..16).
REQ-002 Parameter SB_LAT, default 1, is the shared S-box datapath latency in cycles from sb_in to sb_out (legal 0..3).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to substitute din; sampled only when accepted (see REQ-012).
REQ-006 dec  input  1  direction, sampled with start: 0 = forward S-box (SubBytes), 1 = inverse S-box (InvSubBytes).
REQ-007 din  input  8*NBYTES  state to substitute; byte i = din[8i+7:8i].
REQ-008 busy  output  1  operation in progress.
REQ-009 done  output  1  one-cycle pulse; dout is valid.
REQ-010 dout  output  8*NBYTES  substituted state, byte i = dout[8i+7:8i].
REQ-011 sb_in / sb_dec / sb_valid  output  8 / 1 / 1  byte, direction and qualifier driven to the shared S-box; sb_out  input  8  S-box result, SB_LAT cycles after the issue.

Function
REQ-012 FSM states: IDLE, ISSUE, DRAIN, DONE; start is accepted only in IDLE or DONE and is ignored in ISSUE and DRAIN.
REQ-013 On acceptance in cycle T: the block captures din into an internal source register and latches dec, then enters ISSUE at T+1.
REQ-014 In ISSUE, byte i (0 first, ascending) is presented in cycle T+1+i: sb_valid=1, sb_in=source byte i, sb_dec=latched dec.
REQ-015 sb_valid=0, sb_in=8'h00 and sb_dec=0 in every cycle other than the NBYTES issue cycles.
REQ-016 The block captures sb_out for byte i at the end of cycle T+1+i+SB_LAT into dout byte i, using a capture counter independent of the issue counter.
REQ-017 With SB_LAT=0, the block captures sb_out in the same cycle it issues the byte; DRAIN is skipped, and ISSUE goes directly to DONE.
REQ-018 After the last issue, the FSM enters DRAIN for SB_LAT cycles, then DONE; done=1 only in cycle T+NBYTES+SB_LAT+1.
REQ-019 busy=1 from T+1 through T+NBYTES+SB_LAT inclusive; busy=0 in IDLE and DONE.
REQ-020 DONE lasts exactly one cycle and goes to IDLE unless start=1, in which case REQ-013 applies and ISSUE follows.
REQ-021 dout holds the last completed result until the next accepted start; bytes not yet captured keep their old values during an operation.
REQ-022 Changes to din or dec after acceptance do not affect the running operation.
REQ-023 Counters are ceil(log2(NBYTES+1)) bits wide and never wrap; the issue count stops at NBYTES.

Reset
REQ-024 rst=1 forces the following at the next edge, regardless of state, including mid-ISSUE or DRAIN: state=IDLE, busy=0, done=0, dout=0, sb_valid=0, sb_in=0, sb_dec=0, counters=0, latched dec=0.
REQ-025 The block discards any in-flight S-box results that return after reset, and the aborted operation never produces done.
REQ-026 If start is asserted in the first cycle with rst=0, the block accepts it.

Verification
REQ-027 NBYTES=16, SB_LAT=1, dec=0, din=all 8'h00, start at T -> sb_valid high T+1..T+16; done at T+18; dout=all 8'h63.
REQ-028 dec=1, din byte0=8'h63, byte1=8'h7C, others 8'h52 -> dout byte0=8'h00, byte1=8'h01, others 8'h48; bench S-box model uses the same SB_LAT.
REQ-029 start held high through an entire operation -> only the first start is accepted; the second is accepted in the DONE cycle, with back-to-back done pulses exactly NBYTES+SB_LAT+1 cycles apart.
REQ-030 rst pulsed at T+5 of an operation -> at T+6: busy=0, dout=0, sb_valid=0; no done for the next 40 cycles without start.
REQ-031 SB_LAT=0 and SB_LAT=3, dec=0, din byte i=i -> dout byte i = forward S-box(i) (byte0=8'h63, byte1=8'h7C, byte2=8'h77); done at T+NBYTES+SB_LAT+1.
REQ-032 Change din and dec one cycle after acceptance -> dout reflects the originally captured din and dec.
